// File: rtl/lcd_nibble_receiver_if.sv
// LCD 4-bit bus as seen by a passive receiver: controller-driven strobe/nibble
// inputs and the reassembled-byte outputs.
interface lcd_nibble_receiver_if;
  logic       iLCD_Enabled;
  logic       iLCD_RegisterSelect;
  logic       iLCD_ReadWrite;
  logic       iLCD_StrataFlashControl;
  logic [3:0] iLCD_Data;
  logic [7:0] oByte;
  logic       oByteRS;
  logic       oByteValid;
  logic       oInitDone;
  logic       oProtocolError;

  modport master (
    output iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_StrataFlashControl, iLCD_Data,
    input  oByte, oByteRS, oByteValid, oInitDone, oProtocolError
  );
  modport slave (
    input  iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_StrataFlashControl, iLCD_Data,
    output oByte, oByteRS, oByteValid, oInitDone, oProtocolError
  );
endinterface

// File: rtl/lcd_nibble_receiver.sv
// Snoops an HD44780-style 4-bit LCD bus: tracks the 3,3,3,2 init sequence, then
// pairs nibbles into bytes. Optional strobe-gap checking under LCD_RX_TIMING_CHECK_EN.
module lcd_nibble_receiver #(
  parameter int MIN_E_CYCLES = 12,
  parameter int T_POWERON    = 750000,
  parameter int T_INIT1      = 205000,
  parameter int T_INIT2      = 5000,
  parameter int T_INIT3      = 2000
) (
  input logic            Clock,
  input logic            Reset,
  lcd_nibble_receiver_if.slave bus
);
  localparam int EW = $clog2(MIN_E_CYCLES + 1);
  localparam logic [EW-1:0] EMAX = EW'(MIN_E_CYCLES);

  typedef enum logic [2:0] {INIT_A, INIT_B, INIT_C, INIT_D, HIGH_NIB, LOW_NIB} state_t;

  state_t        state_q, state_d;
  logic          armed_q, e_prev_q;
  logic [EW-1:0] ehi_q, ehi_d;
  logic [3:0]    nib_q, hi_nib_q, hi_nib_d;
  logic          rs_q, rw_q, sf_q, hi_rs_q, hi_rs_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_rs_q, byte_rs_d, valid_q, valid_d, init_q, init_d, err_q, err_d;
  logic          e_act, fall, rise, good, accept;

  // An E that is already high at reset release must be seen low before it counts.
  assign e_act  = bus.iLCD_Enabled & armed_q;
  assign fall   = e_prev_q & ~bus.iLCD_Enabled;
  assign rise   = e_act & ~e_prev_q;
  assign good   = (ehi_q >= EMAX) && !rw_q && sf_q;
  assign accept = fall & good;

  always_comb begin
    ehi_d = '0;
    if (e_act) ehi_d = (ehi_q == EMAX) ? ehi_q : ehi_q + 1'b1;
  end

`ifdef LCD_RX_TIMING_CHECK_EN
  logic [31:0] gap_q, gap_d, gap_min;
  logic        run_q, run_d;
  logic [2:0]  acc_q, acc_d;
  logic        gap_err;

  always_comb begin
    gap_d = gap_q;
    run_d = run_q;
    acc_d = acc_q;
    if (rise) begin
      gap_d = '0;
      run_d = 1'b0;
    end else if (accept) begin
      gap_d = '0;
      run_d = 1'b1;
      if (acc_q != 3'd4) acc_d = acc_q + 3'd1;
    end else if (run_q && gap_q != '1) begin
      gap_d = gap_q + 32'd1;
    end
    case (acc_q)
      3'd0:    gap_min = 32'(T_POWERON);
      3'd1:    gap_min = 32'(T_INIT1);
      3'd2:    gap_min = 32'(T_INIT2);
      default: gap_min = 32'(T_INIT3);
    endcase
    gap_err = rise && (gap_q < gap_min);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      gap_q <= '0;
      run_q <= 1'b1;
      acc_q <= '0;
    end else begin
      gap_q <= gap_d;
      run_q <= run_d;
      acc_q <= acc_d;
    end
  end
`else
  logic gap_err;
  logic unused_timing;
  assign gap_err       = 1'b0;
  assign unused_timing = ^{32'(T_POWERON), 32'(T_INIT1), 32'(T_INIT2), 32'(T_INIT3)};
`endif

  always_comb begin
    state_d   = state_q;
    hi_nib_d  = hi_nib_q;
    hi_rs_d   = hi_rs_q;
    byte_d    = byte_q;
    byte_rs_d = byte_rs_q;
    valid_d   = 1'b0;
    init_d    = init_q;
    err_d     = err_q | gap_err;
    if (fall && !good) err_d = 1'b1;
    if (accept) begin
      case (state_q)
        INIT_A, INIT_B, INIT_C: begin
          if (nib_q == 4'h3 && !rs_q) state_d = state_t'(state_q + 3'd1);
          else begin
            err_d   = 1'b1;
            state_d = INIT_A;
          end
        end
        INIT_D: begin
          if (nib_q == 4'h2 && !rs_q) begin
            state_d = HIGH_NIB;
            init_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = INIT_A;
          end
        end
        HIGH_NIB: begin
          hi_nib_d = nib_q;
          hi_rs_d  = rs_q;
          state_d  = LOW_NIB;
        end
        LOW_NIB: begin
          byte_d    = {hi_nib_q, nib_q};
          byte_rs_d = rs_q;
          if (rs_q != hi_rs_q) err_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = HIGH_NIB;
        end
        default: state_d = INIT_A;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= INIT_A;
      armed_q   <= 1'b0;
      e_prev_q  <= 1'b0;
      ehi_q     <= '0;
      nib_q     <= '0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b0;
      sf_q      <= 1'b0;
      hi_nib_q  <= '0;
      hi_rs_q   <= 1'b0;
      byte_q    <= '0;
      byte_rs_q <= 1'b0;
      valid_q   <= 1'b0;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (!bus.iLCD_Enabled) armed_q <= 1'b1;
      e_prev_q  <= e_act;
      ehi_q     <= ehi_d;
      if (e_act) begin
        nib_q <= bus.iLCD_Data;
        rs_q  <= bus.iLCD_RegisterSelect;
        rw_q  <= bus.iLCD_ReadWrite;
        sf_q  <= bus.iLCD_StrataFlashControl;
      end
      hi_nib_q  <= hi_nib_d;
      hi_rs_q   <= hi_rs_d;
      byte_q    <= byte_d;
      byte_rs_q <= byte_rs_d;
      valid_q   <= valid_d;
      init_q    <= init_d;
      err_q     <= err_d;
    end
  end

  assign bus.oByte          = byte_q;
  assign bus.oByteRS        = byte_rs_q;
  assign bus.oByteValid     = valid_q;
  assign bus.oInitDone      = init_q;
  assign bus.oProtocolError = err_q;
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed bench for lcd_nibble_receiver with scaled-down timing parameters;
// delivered bytes are checked against a queue of expected {RS, byte}.
module tb_lcd_nibble_receiver;
  localparam int MINE = 12;
  localparam int TPO = 200, TI1 = 100, TI2 = 50, TI3 = 20;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  lcd_nibble_receiver_if bif();

  lcd_nibble_receiver #(.MIN_E_CYCLES(MINE), .T_POWERON(TPO), .T_INIT1(TI1),
                        .T_INIT2(TI2), .T_INIT3(TI3)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bif));

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  logic [8:0] expq[$];
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every delivered byte must match the head of the expected queue.
  always @(negedge Clock) begin
    if (Reset && bif.oByteValid) begin
      chk("valid_not_back_to_back", 32'(prev_valid), 32'd0);
      if (expq.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [8:0] e;
        e = expq.pop_front();
        chk("byte", 32'(bif.oByte), 32'(e[7:0]));
        chk("byte_rs", 32'(bif.oByteRS), 32'(e[8]));
      end
    end
    prev_valid = bif.oByteValid;
  end

  task automatic strobe(input logic [3:0] n, input logic rs, input int hi, input int gap,
                        input logic rw = 1'b0, input logic sf = 1'b1);
    @(negedge Clock);
    bif.iLCD_Data = n; bif.iLCD_RegisterSelect = rs;
    bif.iLCD_ReadWrite = rw; bif.iLCD_StrataFlashControl = sf;
    bif.iLCD_Enabled = 1'b1;
    repeat (hi) @(negedge Clock);
    bif.iLCD_Enabled = 1'b0;
    repeat (gap) @(negedge Clock);
  endtask

  task automatic do_reset(input int wait_after);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (wait_after) @(negedge Clock);
  endtask

  task automatic init_seq();
    strobe(4'h3, 1'b0, MINE, TI1 + 5);
    strobe(4'h3, 1'b0, MINE, TI2 + 5);
    strobe(4'h3, 1'b0, MINE, TI3 + 5);
    strobe(4'h2, 1'b0, MINE, TI3 + 5);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs_hi, input logic rs_lo);
    expq.push_back({rs_lo, b});
    strobe(b[7:4], rs_hi, MINE, TI3 + 5);
    strobe(b[3:0], rs_lo, MINE, TI3 + 5);
  endtask

  initial begin
    bif.iLCD_Enabled = 1'b0; bif.iLCD_RegisterSelect = 1'b0; bif.iLCD_ReadWrite = 1'b0;
    bif.iLCD_StrataFlashControl = 1'b1; bif.iLCD_Data = 4'h0;
    repeat (3) @(negedge Clock);
    chk("reset_byte", 32'(bif.oByte), 32'h0);
    chk("reset_rs", 32'(bif.oByteRS), 32'h0);
    chk("reset_valid", 32'(bif.oByteValid), 32'h0);
    chk("reset_init", 32'(bif.oInitDone), 32'h0);
    chk("reset_err", 32'(bif.oProtocolError), 32'h0);
    Reset = 1'b1;
    repeat (TPO + 5) @(negedge Clock);

    // Clean init then two bytes, then an RS mismatch byte.
    init_seq();
    chk("init_done", 32'(bif.oInitDone), 32'd1);
    chk("init_err", 32'(bif.oProtocolError), 32'd0);
    send_byte(8'h41, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b0, 1'b0);
    chk("bytes_err", 32'(bif.oProtocolError), 32'd0);
    send_byte(8'h7E, 1'b0, 1'b1);
    chk("rs_mismatch_err", 32'(bif.oProtocolError), 32'd1);
    chk("init_sticky", 32'(bif.oInitDone), 32'd1);

    // Short strobe: error, state must stay HIGH_NIB.
    do_reset(TPO + 5);
    init_seq();
    strobe(4'h9, 1'b0, MINE - 1, TI3 + 5);
    chk("short_err", 32'(bif.oProtocolError), 32'd1);
    send_byte(8'h42, 1'b0, 1'b0);

    // Read-cycle strobe is rejected without a state change.
    do_reset(TPO + 5);
    init_seq();
    strobe(4'hC, 1'b0, MINE, TI3 + 5, 1'b1, 1'b1);
    chk("rw_err", 32'(bif.oProtocolError), 32'd1);
    send_byte(8'h3C, 1'b1, 1'b1);

    // Wrong value in INIT_B returns to INIT_A; full sequence then completes.
    do_reset(TPO + 5);
    strobe(4'h3, 1'b0, MINE, TI1 + 5);
    strobe(4'h5, 1'b0, MINE, TI2 + 5);
    chk("bad_init_err", 32'(bif.oProtocolError), 32'd1);
    chk("bad_init_notdone", 32'(bif.oInitDone), 32'd0);
    init_seq();
    chk("reinit_done", 32'(bif.oInitDone), 32'd1);
    send_byte(8'h12, 1'b0, 1'b0);

    // Reset after high nibble only: outputs clear, no pulse afterwards.
    do_reset(TPO + 5);
    init_seq();
    strobe(4'h6, 1'b1, MINE, TI3 + 5);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("midbyte_rst_byte", 32'(bif.oByte), 32'h0);
    chk("midbyte_rst_init", 32'(bif.oInitDone), 32'h0);
    chk("midbyte_rst_err", 32'(bif.oProtocolError), 32'h0);
    chk("midbyte_rst_valid", 32'(bif.oByteValid), 32'h0);
    Reset = 1'b1;
    repeat (TPO + 5) @(negedge Clock);
    strobe(4'h9, 1'b1, MINE, TI3 + 5);
    chk("midbyte_low_in_inita_err", 32'(bif.oProtocolError), 32'd1);

    // Early first strobe: only flagged when the gap checker is built.
    do_reset(10);
    strobe(4'h3, 1'b0, MINE, TI1 + 5);
`ifdef LCD_RX_TIMING_CHECK_EN
    chk("early_strobe_err", 32'(bif.oProtocolError), 32'd1);
`else
    chk("early_strobe_err", 32'(bif.oProtocolError), 32'd0);
`endif
    strobe(4'h3, 1'b0, MINE, TI2 + 5);
    strobe(4'h3, 1'b0, MINE, TI3 + 5);
    strobe(4'h2, 1'b0, MINE, TI3 + 5);
    chk("early_init_done", 32'(bif.oInitDone), 32'd1);

    // E already high across reset release is not a strobe.
    @(negedge Clock);
    Reset = 1'b0;
    bif.iLCD_Data = 4'h5; bif.iLCD_Enabled = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (MINE + 8) @(negedge Clock);
    bif.iLCD_Enabled = 1'b0;
    repeat (TPO + 5) @(negedge Clock);
    chk("held_e_err", 32'(bif.oProtocolError), 32'd0);
    init_seq();
    chk("held_e_init_done", 32'(bif.oInitDone), 32'd1);

    repeat (10) @(negedge Clock);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
